// File: rtl/pll_phase_pkg.sv
// Shared types and constants for the PLL dynamic phase-adjust sequencer.
package pll_phase_pkg;

  localparam int unsigned StepsW = 8;
  localparam int unsigned TmrW   = 8;

  localparam logic [1:0] SEL_OUT0 = 2'd0;
  localparam logic [1:0] SEL_OUT2 = 2'd1;
  localparam logic [1:0] SEL_OUT3 = 2'd2;
  localparam logic [1:0] SEL_RSVD = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StRotate,
    StGap,
    StLoad,
    StDone
  } state_e;

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// Step-request handshake between calibration logic and the phase sequencer.
interface pll_phase_ctrl_if;

  logic                             req_valid;
  logic                             req_ready;
  logic [1:0]                       req_sel;
  logic                             req_dir;
  logic [pll_phase_pkg::StepsW-1:0] req_steps;
  logic                             done;
  logic                             err;

  modport master (
    output req_valid, req_sel, req_dir, req_steps,
    input  req_ready, done, err
  );

  modport slave (
    input  req_valid, req_sel, req_dir, req_steps,
    output req_ready, done, err
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous level input; resets to 0.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequencer for the CCC/PLL dynamic phase-adjust port (select, direction, rotate, load).
// Define PLL_PHASE_CTRL_ACCUM_EN to add per-output net-step accumulators.
module pll_phase_ctrl
  import pll_phase_pkg::*;
#(
  parameter int unsigned SetupW = 2,
  parameter int unsigned PulseW = 2,
  parameter int unsigned GapW   = 4
`ifdef PLL_PHASE_CTRL_ACCUM_EN
  ,
  parameter int unsigned AccW   = 8
`endif
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  pll_phase_ctrl_if.slave req_if,
  input  logic            pll_lock_i,
  output logic            phase_out0_sel_o,
  output logic            phase_out2_sel_o,
  output logic            phase_out3_sel_o,
  output logic            phase_direction_o,
  output logic            phase_rotate_o,
  output logic            load_phase_n_o
`ifdef PLL_PHASE_CTRL_ACCUM_EN
  ,
  output logic [AccW-1:0] phase_acc0_o,
  output logic [AccW-1:0] phase_acc2_o,
  output logic [AccW-1:0] phase_acc3_o
`endif
);

  state_e              state_q, state_d;
  logic [TmrW-1:0]     tmr_q, tmr_d;
  logic [StepsW-1:0]   steps_q, steps_d;
  logic [1:0]          sel_q, sel_d;
  logic                dir_q, dir_d;
  logic                err_d, active_d;
  logic                lock_sync, accept;
  logic                sel0_q, sel2_q, sel3_q, pdir_q, rot_q, load_n_q, done_q, err_q;

  sync2 u_lock_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pll_lock_i),
    .q_o    (lock_sync)
  );

  assign req_if.req_ready = (state_q == StIdle) && lock_sync;
  assign accept           = req_if.req_valid && req_if.req_ready;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    steps_d = steps_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sel_d   = req_if.req_sel;
          dir_d   = req_if.req_dir;
          steps_d = req_if.req_steps;
          if (req_if.req_sel == SEL_RSVD) begin
            err_d = 1'b1;
          end else if (req_if.req_steps == '0) begin
            state_d = StDone;
          end else begin
            state_d = StSetup;
            tmr_d   = TmrW'(SetupW - 1);
          end
        end
      end
      StSetup: begin
        if (tmr_q == '0) begin
          state_d = StRotate;
          tmr_d   = TmrW'(PulseW - 1);
          steps_d = steps_q - 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      StRotate: begin
        if (tmr_q == '0) begin
          state_d = StGap;
          tmr_d   = TmrW'(GapW - 1);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      StGap: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (steps_q != '0) begin
          state_d = StRotate;
          tmr_d   = TmrW'(PulseW - 1);
          steps_d = steps_q - 1'b1;
        end else begin
          state_d = StLoad;
        end
      end
      StLoad:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Lock loss overrides every in-flight transition.
    if ((state_q != StIdle) && !lock_sync) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end
  end

  assign active_d = state_d inside {StSetup, StRotate, StGap, StLoad};

  // PLL pins are decoded from next state so every pin comes straight off a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      tmr_q    <= '0;
      steps_q  <= '0;
      sel_q    <= SEL_OUT0;
      dir_q    <= 1'b0;
      sel0_q   <= 1'b0;
      sel2_q   <= 1'b0;
      sel3_q   <= 1'b0;
      pdir_q   <= 1'b0;
      rot_q    <= 1'b0;
      load_n_q <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      steps_q  <= steps_d;
      sel_q    <= sel_d;
      dir_q    <= dir_d;
      sel0_q   <= active_d && (sel_d == SEL_OUT0);
      sel2_q   <= active_d && (sel_d == SEL_OUT2);
      sel3_q   <= active_d && (sel_d == SEL_OUT3);
      pdir_q   <= active_d && dir_d;
      rot_q    <= (state_d == StRotate);
      load_n_q <= (state_d != StLoad);
      done_q   <= (state_d == StDone);
      err_q    <= err_d;
    end
  end

  assign phase_out0_sel_o  = sel0_q;
  assign phase_out2_sel_o  = sel2_q;
  assign phase_out3_sel_o  = sel3_q;
  assign phase_direction_o = pdir_q;
  assign phase_rotate_o    = rot_q;
  assign load_phase_n_o    = load_n_q;
  assign req_if.done       = done_q;
  assign req_if.err        = err_q;

`ifdef PLL_PHASE_CTRL_ACCUM_EN
  logic [AccW-1:0] acc0_q, acc2_q, acc3_q, delta;
  logic            rot_entry;

  assign rot_entry = (state_d == StRotate) && (state_q != StRotate);
  assign delta     = dir_q ? AccW'(1) : '1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc0_q <= '0;
      acc2_q <= '0;
      acc3_q <= '0;
    end else if (rot_entry) begin
      case (sel_q)
        SEL_OUT0: acc0_q <= acc0_q + delta;
        SEL_OUT2: acc2_q <= acc2_q + delta;
        SEL_OUT3: acc3_q <= acc3_q + delta;
        default:  ;
      endcase
    end
  end

  assign phase_acc0_o = acc0_q;
  assign phase_acc2_o = acc2_q;
  assign phase_acc3_o = acc3_q;
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Self-checking bench for pll_phase_ctrl: per-request traces against a schedule model.
module tb_pll_phase_ctrl;

  localparam int S = 2;
  localparam int P = 2;
  localparam int G = 4;

  typedef struct {
    logic [63:0] rot, ld, dn, er, s0, s2, s3, dr, rdy;
  } trace_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_lock = 1'b0;
  logic out0, out2, out3, pdir, prot, load_n;
`ifdef PLL_PHASE_CTRL_ACCUM_EN
  logic [7:0] acc0, acc2, acc3;
`endif

  int checks = 0;
  int failures = 0;
  int acc_m[3];

  pll_phase_ctrl_if bus ();

  always #5 clk = ~clk;

  pll_phase_ctrl #(
    .SetupW (S),
    .PulseW (P),
    .GapW   (G)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .req_if            (bus),
    .pll_lock_i        (pll_lock),
    .phase_out0_sel_o  (out0),
    .phase_out2_sel_o  (out2),
    .phase_out3_sel_o  (out3),
    .phase_direction_o (pdir),
    .phase_rotate_o    (prot),
    .load_phase_n_o    (load_n)
`ifdef PLL_PHASE_CTRL_ACCUM_EN
    ,
    .phase_acc0_o      (acc0),
    .phase_acc2_o      (acc2),
    .phase_acc3_o      (acc3)
`endif
  );

`ifdef PLL_PHASE_CTRL_ACCUM_EN
  function automatic int acc_dut(input int idx);
    return (idx == 0) ? int'(acc0) : (idx == 1) ? int'(acc2) : int'(acc3);
  endfunction
`endif

  function automatic logic [8:0] pins();
    return {bus.req_ready, bus.done, bus.err, out0, out2, out3, pdir, prot, load_n};
  endfunction

  // Bit k of each trace vector is the output seen in cycle k after the accepting edge.
  task automatic issue(input logic [1:0] sel, input logic dir, input logic [7:0] steps,
                       output bit ok, output trace_t tr);
    tr = '{default: '0};
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.req_ready;
    end
    if (!ok) return;
    bus.req_valid = 1'b1;
    bus.req_sel   = sel;
    bus.req_dir   = dir;
    bus.req_steps = steps;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      tr.rot[k] = prot;
      tr.ld[k]  = ~load_n;
      tr.dn[k]  = bus.done;
      tr.er[k]  = bus.err;
      tr.s0[k]  = out0;
      tr.s2[k]  = out2;
      tr.s3[k]  = out3;
      tr.dr[k]  = pdir;
      tr.rdy[k] = bus.req_ready;
    end
  endtask

  // Expected schedule for a valid request with n >= 1 steps, from the timing rules.
  task automatic model_req(input int n, input int sel, input bit dir, output trace_t ex);
    int ld_c;
    ex   = '{default: '0};
    ld_c = 1 + S + n * (P + G);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < P; j++) ex.rot[1 + S + i * (P + G) + j] = 1'b1;
    ex.ld[ld_c]     = 1'b1;
    ex.dn[ld_c + 1] = 1'b1;
    for (int k = 1; k <= ld_c; k++) begin
      ex.s0[k] = (sel == 0);
      ex.s2[k] = (sel == 1);
      ex.s3[k] = (sel == 2);
      ex.dr[k] = dir;
    end
    for (int k = ld_c + 2; k < 64; k++) ex.rdy[k] = 1'b1;
    acc_m[sel] = (acc_m[sel] + (dir ? n : -n)) & 255;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0;
    bus.req_sel   = 2'd0;
    bus.req_dir   = 1'b0;
    bus.req_steps = 8'd0;
    rst_n         = 1'b0;
    pll_lock      = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pins() !== 9'b0_0000_0001) begin
      failures++;
      $display("FAIL reset_pins got=%b exp=%b", pins(), 9'b0_0000_0001);
    end
`ifdef PLL_PHASE_CTRL_ACCUM_EN
    checks++;
    if ({acc0, acc2, acc3} !== 24'h0) begin
      failures++;
      $display("FAIL reset_acc got=%h exp=000000", {acc0, acc2, acc3});
    end
`endif
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_without_lock got=%b exp=0", bus.req_ready);
    end
    pll_lock = 1'b1;
    begin
      int n = 0;
      while (bus.req_ready !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n != 2) begin
        failures++;
        $display("FAIL ready_after_lock got_cycles=%0d exp=2", n);
      end
    end
  endtask

  task automatic test_basic();
    trace_t tr, ex;
    bit ok;
    issue(2'd0, 1'b1, 8'd3, ok, tr);
    model_req(3, 0, 1'b1, ex);
    checks++;
    if (!ok || {tr.rot, tr.ld, tr.dn} !== {ex.rot, ex.ld, ex.dn}) begin
      failures++;
      $display("FAIL basic_seq ok=%0d got=%h exp=%h", ok, {tr.rot, tr.ld, tr.dn},
               {ex.rot, ex.ld, ex.dn});
    end
    checks++;
    if ({tr.s0, tr.s2, tr.s3, tr.dr} !== {ex.s0, ex.s2, ex.s3, ex.dr}) begin
      failures++;
      $display("FAIL basic_sel got=%h exp=%h", {tr.s0, tr.s2, tr.s3, tr.dr},
               {ex.s0, ex.s2, ex.s3, ex.dr});
    end
    checks++;
    if (tr.rdy !== ex.rdy || tr.er !== 64'h0) begin
      failures++;
      $display("FAIL basic_ready got=%h/%h exp=%h/0", tr.rdy, tr.er, ex.rdy);
    end
`ifdef PLL_PHASE_CTRL_ACCUM_EN
    checks++;
    if (acc_dut(0) != acc_m[0]) begin
      failures++;
      $display("FAIL basic_acc0 got=%0d exp=%0d", acc_dut(0), acc_m[0]);
    end
`endif
  endtask

  task automatic test_wrap();
    trace_t tr, ex;
    bit ok;
    issue(2'd2, 1'b0, 8'd1, ok, tr);
    model_req(1, 2, 1'b0, ex);
    checks++;
    if (!ok || {tr.rot, tr.ld, tr.dn, tr.s3} !== {ex.rot, ex.ld, ex.dn, ex.s3}) begin
      failures++;
      $display("FAIL wrap_seq ok=%0d got=%h exp=%h", ok, {tr.rot, tr.ld, tr.dn, tr.s3},
               {ex.rot, ex.ld, ex.dn, ex.s3});
    end
`ifdef PLL_PHASE_CTRL_ACCUM_EN
    checks++;
    if (acc_dut(2) != 255) begin
      failures++;
      $display("FAIL wrap_acc3 got=%0d exp=255", acc_dut(2));
    end
`endif
  endtask

  task automatic test_reserved();
    trace_t tr;
    bit ok;
    issue(2'd3, 1'b1, 8'd5, ok, tr);
    checks++;
    if (!ok || tr.er !== 64'd2 || tr.dn !== 64'h0) begin
      failures++;
      $display("FAIL rsvd_err ok=%0d err=%h done=%h exp_err=2", ok, tr.er, tr.dn);
    end
    checks++;
    if ((tr.rot | tr.ld | tr.s0 | tr.s2 | tr.s3 | tr.dr) !== 64'h0) begin
      failures++;
      $display("FAIL rsvd_pins got=%h exp=0", tr.rot | tr.ld | tr.s0 | tr.s2 | tr.s3 | tr.dr);
    end
    checks++;
    if (tr.rdy !== ~64'd1) begin
      failures++;
      $display("FAIL rsvd_ready got=%h exp=%h", tr.rdy, ~64'd1);
    end
  endtask

  task automatic test_zero_steps();
    trace_t tr;
    bit ok;
    issue(2'd1, 1'b1, 8'd0, ok, tr);
    checks++;
    if (!ok || tr.dn !== 64'd2 || tr.er !== 64'h0) begin
      failures++;
      $display("FAIL zero_done ok=%0d done=%h err=%h exp_done=2", ok, tr.dn, tr.er);
    end
    checks++;
    if ((tr.rot | tr.ld | tr.s0 | tr.s2 | tr.s3 | tr.dr) !== 64'h0) begin
      failures++;
      $display("FAIL zero_pins got=%h exp=0", tr.rot | tr.ld | tr.s0 | tr.s2 | tr.s3 | tr.dr);
    end
  endtask

  task automatic test_random();
    trace_t tr, ex;
    bit ok;
    for (int r = 0; r < 10; r++) begin
      int sel = $urandom_range(0, 2);
      bit dir = 1'($urandom_range(0, 1));
      int n   = $urandom_range(1, 8);
      issue(2'(sel), dir, 8'(n), ok, tr);
      model_req(n, sel, dir, ex);
      checks++;
      if (!ok || {tr.rot, tr.ld, tr.dn, tr.er} !== {ex.rot, ex.ld, ex.dn, ex.er}) begin
        failures++;
        $display("FAIL rand_seq r=%0d n=%0d got=%h exp=%h", r, n, {tr.rot, tr.ld, tr.dn, tr.er},
                 {ex.rot, ex.ld, ex.dn, ex.er});
      end
      checks++;
      if ({tr.s0, tr.s2, tr.s3, tr.dr, tr.rdy} !== {ex.s0, ex.s2, ex.s3, ex.dr, ex.rdy}) begin
        failures++;
        $display("FAIL rand_sel r=%0d sel=%0d got=%h exp=%h", r, sel,
                 {tr.s0, tr.s2, tr.s3, tr.dr, tr.rdy}, {ex.s0, ex.s2, ex.s3, ex.dr, ex.rdy});
      end
`ifdef PLL_PHASE_CTRL_ACCUM_EN
      checks++;
      if (acc_dut(sel) != acc_m[sel]) begin
        failures++;
        $display("FAIL rand_acc r=%0d sel=%0d got=%0d exp=%0d", r, sel, acc_dut(sel), acc_m[sel]);
      end
`endif
    end
  endtask

  task automatic test_lock_loss();
    int  rises = 0, err_cyc = -1, dones = 0, unsafe = 0, n = 0;
    logic prev_rot = 1'b0;
    bit   ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.req_ready;
    end
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'd1;
    bus.req_dir   = 1'b1;
    bus.req_steps = 8'd5;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (prot && !prev_rot) rises++;
      prev_rot = prot;
      if (bus.err && err_cyc < 0) err_cyc = k;
      if (bus.done) dones++;
      if (err_cyc >= 0 && (prot || !load_n || out0 || out2 || out3 || pdir)) unsafe++;
      if (k == 9) pll_lock = 1'b0;
    end
    acc_m[1] = (acc_m[1] + 2) & 255;
    checks++;
    if (!ok || err_cyc < 10 || err_cyc > 14) begin
      failures++;
      $display("FAIL lock_err ok=%0d got_cycle=%0d exp=10..14", ok, err_cyc);
    end
    checks++;
    if (rises != 2 || dones != 0 || unsafe != 0) begin
      failures++;
      $display("FAIL lock_safe rises=%0d dones=%0d unsafe=%0d exp=2/0/0", rises, dones, unsafe);
    end
    checks++;
    if (bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL lock_ready_low got=%b exp=0", bus.req_ready);
    end
`ifdef PLL_PHASE_CTRL_ACCUM_EN
    checks++;
    if (acc_dut(1) != acc_m[1]) begin
      failures++;
      $display("FAIL lock_acc2 got=%0d exp=%0d", acc_dut(1), acc_m[1]);
    end
`endif
    pll_lock = 1'b1;
    while (bus.req_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL lock_ready_back got=%b exp=1", bus.req_ready);
    end
  endtask

  task automatic test_reset_mid();
    trace_t tr, ex;
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.req_ready;
    end
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'd0;
    bus.req_dir   = 1'b1;
    bus.req_steps = 8'd4;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || pins() !== 9'b0_0000_0001) begin
      failures++;
      $display("FAIL midreset_pins ok=%0d got=%b exp=%b", ok, pins(), 9'b0_0000_0001);
    end
`ifdef PLL_PHASE_CTRL_ACCUM_EN
    checks++;
    if ({acc0, acc2, acc3} !== 24'h0) begin
      failures++;
      $display("FAIL midreset_acc got=%h exp=000000", {acc0, acc2, acc3});
    end
`endif
    acc_m = '{0, 0, 0};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(2'd2, 1'b1, 8'd2, ok, tr);
    model_req(2, 2, 1'b1, ex);
    checks++;
    if (!ok || {tr.rot, tr.ld, tr.dn, tr.s3} !== {ex.rot, ex.ld, ex.dn, ex.s3}) begin
      failures++;
      $display("FAIL midreset_after ok=%0d got=%h exp=%h", ok, {tr.rot, tr.ld, tr.dn, tr.s3},
               {ex.rot, ex.ld, ex.dn, ex.s3});
    end
`ifdef PLL_PHASE_CTRL_ACCUM_EN
    checks++;
    if (acc_dut(2) != acc_m[2] || acc_dut(0) != 0) begin
      failures++;
      $display("FAIL midreset_acc3 got=%0d/%0d exp=%0d/0", acc_dut(2), acc_dut(0), acc_m[2]);
    end
`endif
  endtask

  initial begin
    acc_m = '{0, 0, 0};
    test_reset();
    test_basic();
    test_wrap();
    test_reserved();
    test_zero_steps();
    test_random();
    test_lock_loss();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/pll_phase_ctrl.md
# pll_phase_ctrl

Fabric-side sequencer that drives the dynamic phase-adjust port of the DDR4 controller CCC/PLL: PHASE_OUTx_SEL, PHASE_DIRECTION, PHASE_ROTATE and LOAD_PHASE_N. It accepts step requests over a valid/ready handshake, issues one PHASE_ROTATE pulse per step, then loads the new phase. It aborts on PLL lock loss and optionally tracks the net phase offset per output. It sits between the DDR4 training/calibration logic and the CCC instance.

## Interface
- SETUP_W, 2 — cycles select/direction are held stable before the first rotate pulse.
- PULSE_W, 2 — PHASE_ROTATE high time in cycles per step.
- GAP_W, 4 — PHASE_ROTATE low time in cycles after each pulse.
- ACC_W, 8 — width of per-output phase accumulators.
- CLK  in  1  fabric clock (same domain as requester)
- RESET_N  in  1  asynchronous, active-low reset
- REQ_VALID  in  1  request strobe
- REQ_READY  out  1  block idle and PLL locked
- REQ_SEL  in  2  target: 0=OUT0, 1=OUT2, 2=OUT3, 3=reserved
- REQ_DIR  in  1  1=advance, 0=retard
- REQ_STEPS  in  8  number of rotate steps
- DONE  out  1  one-cycle pulse, request completed
- ERR  out  1  one-cycle pulse, request rejected or aborted
- PLL_LOCK  in  1  PLL lock, asynchronous; 2-flop synchronized internally
- PHASE_OUT0_SEL, PHASE_OUT2_SEL, PHASE_OUT3_SEL  out  1 each  output select to PLL
- PHASE_DIRECTION  out  1  direction to PLL
- PHASE_ROTATE  out  1  rotate strobe to PLL
- LOAD_PHASE_N  out  1  active-low phase load to PLL
- PHASE_ACC0, PHASE_ACC2, PHASE_ACC3  out  ACC_W each  net step count (only with macro)

## Operation
- Reset values: REQ_READY=0, DONE=0, ERR=0, all SEL=0, PHASE_DIRECTION=0, PHASE_ROTATE=0, LOAD_PHASE_N=1, accumulators=0. The state is IDLE.
- REQ_READY = (state==IDLE) & lock_sync. A request is accepted on REQ_VALID & REQ_READY, and SEL, DIR and STEPS are latched.
- States:
  - IDLE.
  - SETUP: the selected PHASE_OUTx_SEL and PHASE_DIRECTION are driven for SETUP_W cycles.
  - ROTATE: PHASE_ROTATE=1 for PULSE_W cycles; the step counter decrements on entry.
  - GAP: PULSE low for GAP_W cycles. The block then goes back to ROTATE if steps remain, otherwise to LOAD.
  - LOAD: LOAD_PHASE_N=0 for 1 cycle.
  - DONE: SEL is deasserted and DONE pulses. The block then returns to IDLE.
- SEL and DIRECTION stay constant from SETUP through LOAD inclusive.
- REQ_SEL=3: the request is accepted, ERR pulses the next cycle, the PLL outputs do not change, and the block stays in IDLE.
- REQ_STEPS=0: the request is accepted, DONE pulses the next cycle, and the PLL outputs do not change.
- Lock loss (lock_sync=0 in any state other than IDLE): the block goes to IDLE on the next cycle.
  - ROTATE and SEL are forced to 0 and LOAD_PHASE_N to 1.
  - ERR pulses and DONE is not asserted.
  - Steps already issued remain counted in the accumulators.
- Accumulator arithmetic: on each ROTATE entry, the selected accumulator adds +1 (DIR=1) or −1 (DIR=0), modulo 2^ACC_W. Wrap-around is silent.
- Reset asserted mid-operation returns all outputs to their reset values immediately (asynchronous).

## Timing
- Accept at cycle 0, with N≥1 steps:
  - First PHASE_ROTATE rise at cycle 1+SETUP_W.
  - LOAD_PHASE_N low at cycle 1+SETUP_W+N·(PULSE_W+GAP_W).
  - DONE high the cycle after LOAD_PHASE_N low.
  - REQ_READY returns the cycle after DONE.
- With defaults and N=3: rotate rises at cycles 3, 9, 15; LOAD at 21; DONE at 22.
- Lock loss: outputs are safe one cycle after lock_sync falls, which is 3 cycles after PLL_LOCK falls.
- All outputs are registered and glitch-free; there is no combinational path from inputs to PLL pins.

## Configuration
- PLL_PHASE_CTRL_ACCUM_EN defined: the three accumulators and the PHASE_ACCx ports exist.
- Not defined: the accumulators and ports are absent. All other behaviour is identical.

## Structure
- Shared package pll_phase_pkg holds:
  - the state enum (IDLE, SETUP, ROTATE, GAP, LOAD, DONE);
  - the SEL encoding constants SEL_OUT0=0, SEL_OUT2=1, SEL_OUT3=2, SEL_RSVD=3.
- One sub-module, sync2, is the 2-flop synchronizer for PLL_LOCK. Everything else lives in a single FSM module.

## Test plan
- Lock=1, request SEL=0, DIR=1, STEPS=3 → PHASE_OUT0_SEL high during cycles 1–21, ROTATE rises at 3/9/15, LOAD_PHASE_N low at 21, DONE at 22, ACC0=3.
- Request SEL=2, DIR=0, STEPS=1 from ACC3=0 → one rotate pulse, ACC3=0xFF (wrap), DONE at cycle 10.
- REQ_SEL=3 → ERR at cycle 1, all PLL outputs unchanged, REQ_READY back at cycle 1.
- STEPS=0 → DONE at cycle 1, no ROTATE and no LOAD.
- STEPS=5, PLL_LOCK dropped at cycle 10 → ERR within 4 cycles, ROTATE=0, LOAD_PHASE_N=1, ACC equals the pulses issued (2), REQ_READY stays 0 until lock returns.
- RESET_N asserted during GAP → all outputs at reset values in the same cycle; after release the block is IDLE and a new request completes normally.
